// File: rtl/i2s_rx.sv
// i2s_rx: two-channel MSB-first serial audio receiver (I2S / LJ / RJ).
// Optional framing-error flag when I2S_RX_ERR_EN is defined.
module i2s_rx #(
  parameter int RESOLUTION = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  SCLK,
  input  logic                  RST_N,
  input  logic                  LRCK,
  input  logic                  data_in,
  input  logic [1:0]            fmt,
  output logic [RESOLUTION-1:0] data_out_L,
  output logic [RESOLUTION-1:0] data_out_R,
  output logic                  valid,
  output logic                  err
);

  localparam int CW = $clog2(SLOT_WIDTH + 2);
`ifdef I2S_RX_ERR_EN
  localparam int SAT = SLOT_WIDTH + 1;
`else
  localparam int SAT = RESOLUTION;
`endif
  localparam logic [CW-1:0] CNT_SAT = CW'(SAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    SYNC,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            fmt_q, fmt_d, fmt_eff;
  logic                  lrck_dly_q;
  logic                  lr_q;
  logic                  eff_lr;
  logic                  is_i2s, is_rj;
  logic                  slot_edge, fall, rise;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RESOLUTION-1:0] sr_q, sr_d;
  logic [RESOLUTION-1:0] hold_q;
  logic [RESOLUTION-1:0] out_l_q, out_r_q;
  logic                  valid_q;

  // Framing decode and slot-edge detection on the effective word select
  always_comb begin
    fmt_eff   = (state_q == RUN) ? fmt_q : fmt;
    is_rj     = (fmt_eff == 2'd2);
    is_i2s    = (fmt_eff == 2'd0) || (fmt_eff == 2'd3);
    eff_lr    = is_i2s ? lrck_dly_q : LRCK;
    slot_edge = eff_lr ^ lr_q;
    fall      = slot_edge & ~eff_lr;
    rise      = slot_edge & eff_lr;
  end

  // Slot bit counter: position of the next bit, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (slot_edge) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q < CNT_SAT) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Slot shift register: positional fill (LJ/I2S) or plain shift (RJ)
  always_comb begin
    sr_d = sr_q;
    if (is_rj) begin
      if (slot_edge) begin
        sr_d = '0;
      end else begin
        sr_d = sr_q << 1;
      end
      sr_d[0] = data_in;
    end else if (slot_edge) begin
      sr_d = '0;
      sr_d[RESOLUTION-1] = data_in;
    end else begin
      for (int i = 0; i < RESOLUTION; i++) begin
        if (int'(cnt_q) == RESOLUTION - 1 - i) begin
          sr_d[i] = data_in;
        end
      end
    end
  end

  // Sync FSM: wait for the first left-slot start, then lock the format
  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    unique case (state_q)
      SYNC: begin
        if (fall) begin
          state_d = RUN;
          fmt_d   = fmt;
        end
      end
      RUN: begin
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // Front-end state: delay flop, edge history, counter, shifter, FSM
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      lrck_dly_q <= 1'b0;
      lr_q       <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      state_q    <= SYNC;
      fmt_q      <= 2'd0;
    end else begin
      lrck_dly_q <= LRCK;
      lr_q       <= eff_lr;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      state_q    <= state_d;
      fmt_q      <= fmt_d;
    end
  end

  // Word hand-off: park left at right-slot start, emit pair at left start
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q  <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == RUN && rise) begin
        hold_q <= sr_q;
      end
      if (state_q == RUN && fall) begin
        out_l_q <= hold_q;
        out_r_q <= sr_q;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_ERR_EN
  logic bad_slot;
  logic err_l_q;
  logic err_q;

  // A finished slot is bad if too short for a word or over-long
  always_comb begin
    bad_slot = (cnt_q < CW'(RESOLUTION)) ||
               (cnt_q == CW'(SLOT_WIDTH + 1));
  end

  // Error flag: left status parked, pair status loaded with valid
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      err_l_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == RUN && rise) begin
        err_l_q <= bad_slot;
      end
      if (state_q == RUN && fall) begin
        err_q <= err_l_q | bad_slot;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign data_out_L = out_l_q;
  assign data_out_R = out_r_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed + random frame streams against a slot-level model.
// Expected words come from slot contents and the framing rules.
module tb_i2s_rx;

  localparam int RES = 24;
  localparam int SW  = 32;
  localparam logic [63:0] MASK = (64'd1 << RES) - 64'd1;

  logic           SCLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           LRCK = 1'b0;
  logic           data_in = 1'b0;
  logic [1:0]     fmt = 2'd0;
  logic [RES-1:0] data_out_L, data_out_R;
  logic           valid, err;

  int checks = 0;
  int failures = 0;

`ifdef I2S_RX_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  always #5 SCLK = ~SCLK;

  i2s_rx #(
    .RESOLUTION(RES),
    .SLOT_WIDTH(SW)
  ) dut (
    .SCLK      (SCLK),
    .RST_N     (RST_N),
    .LRCK      (LRCK),
    .data_in   (data_in),
    .fmt       (fmt),
    .data_out_L(data_out_L),
    .data_out_R(data_out_R),
    .valid     (valid),
    .err       (err)
  );

  // slot list: even index = right slot (LRCK=1), odd = left slot
  int          s_len[$];
  logic [63:0] s_bits[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_slot(input int n, input logic [63:0] b);
    s_len.push_back(n);
    s_bits.push_back((n >= 64) ? b : (b & ((64'd1 << n) - 64'd1)));
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // word a receiver should deliver for slot i under format f
  function automatic logic [63:0] word_of(input int i, input logic [1:0] f);
    int n = s_len[i];
    logic [63:0] b = s_bits[i];
    if (f == 2'd2) return b & MASK;
    if (n >= RES) return (b >> (n - RES)) & MASK;
    return (b << (RES - n)) & MASK;
  endfunction

  function automatic bit bad(input int n);
    return ERR_ON && (n < RES || n > SW);
  endfunction

  // pre-sync right slot, nfr fixed-size L/R frames, trailing left slot
  function automatic void frames_fixed(input int nfr, input int n,
                                       input logic [63:0] bl,
                                       input logic [63:0] br);
    s_len.delete();
    s_bits.delete();
    add_slot(n, rnd64());
    for (int k = 0; k < nfr; k++) begin
      add_slot(n, bl);
      add_slot(n, br);
    end
    add_slot(4, rnd64());
  endfunction

  // reset, then play the slot list; trunc>0 stops early mid-stream
  task automatic run(input logic [1:0] f, input int trunc, input bit chg);
    bit          lr_c[$];
    bit          d_c[$];
    int          start[$];
    bit          ev[];
    logic [63:0] el[], er[];
    bit          ee[];
    logic [63:0] cur_l, cur_r;
    bit          cur_e;
    bit          i2s;
    int          ncyc, chgc;
    for (int i = 0; i < s_len.size(); i++) begin
      start.push_back(lr_c.size());
      for (int j = s_len[i] - 1; j >= 0; j--) begin
        lr_c.push_back(i % 2 == 0);
        d_c.push_back(s_bits[i][j]);
      end
    end
    ncyc = lr_c.size();
    if (trunc > 0 && trunc < ncyc) ncyc = trunc;
    i2s = (f == 2'd0) || (f == 2'd3);
    ev = new[ncyc];
    el = new[ncyc];
    er = new[ncyc];
    ee = new[ncyc];
    for (int i = 3; i < s_len.size(); i += 2) begin
      int c = start[i] + (i2s ? 1 : 0);
      if (c < ncyc) begin
        ev[c] = 1'b1;
        el[c] = word_of(i - 2, f);
        er[c] = word_of(i - 1, f);
        ee[c] = bad(s_len[i-2]) | bad(s_len[i-1]);
      end
    end
    chgc = (s_len.size() > 3) ? start[3] : -1;
    @(negedge SCLK);
    RST_N = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_L", 64'(data_out_L), 64'd0);
    chk("rst_R", 64'(data_out_R), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    fmt = f;
    cur_l = '0;
    cur_r = '0;
    cur_e = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge SCLK);
      RST_N = 1'b1;
      LRCK = lr_c[c];
      data_in = i2s ? ((c == 0) ? 1'b0 : d_c[c-1]) : d_c[c];
      if (chg && c == chgc) fmt = f ^ 2'b01;
      @(posedge SCLK);
      #1;
      chk("valid", 64'(valid), 64'(ev[c]));
      if (ev[c]) begin
        cur_l = el[c];
        cur_r = er[c];
        cur_e = ee[c];
      end
      if (ev[c] || c == ncyc - 1) begin
        chk("data_L", 64'(data_out_L), cur_l);
        chk("data_R", 64'(data_out_R), cur_r);
        chk("err", 64'(err), 64'(cur_e));
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge SCLK);
    // I2S, nominal words
    frames_fixed(4, 32, (64'hA5A5A5 << 8) | 64'(8'($urandom)),
                 (64'h123456 << 8) | 64'(8'($urandom)));
    run(2'd0, 0, 1'b0);
    // left-justified, same words, one cycle earlier
    frames_fixed(4, 32, (64'hA5A5A5 << 8) | 64'(8'($urandom)),
                 (64'h123456 << 8) | 64'(8'($urandom)));
    run(2'd1, 0, 1'b0);
    // right-justified with 0xFF padding ahead of the word
    frames_fixed(4, 32, 64'hFFA5A5A5, 64'hFF123456);
    run(2'd2, 0, 1'b0);
    // LJ with 16-cycle slots: short words, zero-filled LSBs
    frames_fixed(3, 16, 64'hABCD, 64'($urandom_range(0, 65535)));
    run(2'd1, 0, 1'b0);
    // I2S stream cut by reset in the middle of a right slot
    frames_fixed(4, 32, rnd64(), rnd64());
    run(2'd0, 4 * 32 + 10, 1'b0);
    // restart as if mid right slot; reset check happens first
    frames_fixed(3, 32, rnd64(), rnd64());
    run(2'd0, 0, 1'b1);
    // one over-long right slot, then normal frames
    s_len.delete();
    s_bits.delete();
    add_slot(32, rnd64());
    add_slot(32, rnd64());
    add_slot(40, rnd64());
    for (int k = 0; k < 2; k++) begin
      add_slot(32, rnd64());
      add_slot(32, rnd64());
    end
    add_slot(4, rnd64());
    run(2'd1, 0, 1'b0);
    // random formats, random slot lengths including 1 and over-long
    for (int r = 0; r < 8; r++) begin
      int nfr = $urandom_range(3, 5);
      s_len.delete();
      s_bits.delete();
      add_slot($urandom_range(1, 40), rnd64());
      for (int k = 0; k < 2 * nfr; k++) begin
        add_slot(($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 32,
                 rnd64());
      end
      add_slot($urandom_range(2, 8), rnd64());
      run(2'($urandom_range(0, 3)), 0, 1'(r % 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
